uart_txrx_param: RTL
====================

Name: uart_txrx_param

Overview:
Parametrised UART transceiver and the next generation of the team's fixed 8N1 TX/RX pair. It is generalised in data width, parity mode and stop-bit count, and adds line-error reporting, a TX ready handshake and a runtime-selectable internal loopback. It sits between a byte-stream client and the external serial pins, one instance per UART channel.

Parameters:
- CLOCKS_PER_BIT, 217, clk cycles per serial bit (clk freq / baud); legal range >= 4.
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted per frame; legal values 1 or 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_tx_valid  in  1  TX request; frame accepted when i_tx_valid && o_tx_ready.
- i_tx_data  in  DATA_BITS  payload, sampled on the accept cycle.
- o_tx_ready  out  1  TX idle and able to accept a frame.
- o_tx_done  out  1  one-cycle pulse at end of the last stop bit.
- o_tx_serial  out  1  serial line out; idle high.
- i_rx_serial  in  1  serial line in; asynchronous to clk.
- i_loopback  in  1  1: RX is fed from the internal TX line and o_tx_serial is held high.
- o_rx_valid  out  1  one-cycle pulse; received frame available.
- o_rx_data  out  DATA_BITS  last received payload; held until next o_rx_valid.
- o_parity_err  out  1  parity mismatch on last frame; updated with o_rx_valid; 0 when PARITY=0.
- o_frame_err  out  1  first stop bit sampled low on last frame; updated with o_rx_valid.

Behaviour:
Reset values (rst high at a clk edge):
- Both FSMs go to IDLE and all counters clear.
- o_tx_serial=1, o_tx_ready=1, o_tx_done=0, o_rx_valid=0, o_rx_data=0, o_parity_err=0, o_frame_err=0.
- Reset mid-frame aborts the frame immediately; no done or valid pulse is produced.

TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept on the cycle i_tx_valid && o_tx_ready; the payload is latched. o_tx_ready drops on the next cycle, and the line goes low in that same cycle.
- Each bit is held exactly CLOCKS_PER_BIT cycles.
- DATA state sends DATA_BITS bits, LSB first.
- PARITY state is present only if PARITY!=0. The bit is XOR of the payload, inverted for odd parity.
- STOP state holds the line high for STOP_BITS*CLOCKS_PER_BIT cycles.
- On the final STOP cycle's following edge: o_tx_done pulses for 1 cycle and o_tx_ready returns to 1 in the same cycle.
- A new accept is possible in that same cycle, giving back-to-back frames with no idle gap.
- i_tx_valid while o_tx_ready=0 is ignored; no queueing.

RX input path:
- RX source is the internal TX line when i_loopback=1, else i_rx_serial.
- The source passes through a 2-flop synchroniser to form the sampled line.
- i_loopback changes are legal only while both FSMs are IDLE; behaviour of a frame in flight during a change is not guaranteed.

RX FSM: IDLE -> START_CHK -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: a high-to-low transition of the sampled line enters START_CHK.
- START_CHK: after CLOCKS_PER_BIT/2 (integer division) cycles, re-sample the line. Low proceeds to DATA; high returns to IDLE as a glitch, with no output.
- All later samples are taken every CLOCKS_PER_BIT cycles, i.e. at bit centres.
- Data bits shift in LSB first. If PARITY!=0, the received parity bit is compared against the computed parity.
- STOP: sample the first stop bit only. One cycle after this sample:
  - o_rx_valid=1 and o_rx_data updates.
  - o_parity_err and o_frame_err update for this frame.
  - FSM returns to IDLE.
- A frame with errors still pulses o_rx_valid, with its data and error flags.
- After a frame error, if the line is still low, the RX does not start a new frame until a fresh high-to-low transition is seen.
- RX never depends on STOP_BITS, so it tolerates a sender using 1 or 2 stop bits.

Widths and arithmetic:
- Bit-period counter width is $clog2(CLOCKS_PER_BIT).
- Bit-index counter width is $clog2(DATA_BITS+1).
- Counters wrap to 0 at bit end; there is no free-running overflow.

Simultaneous events:
- o_tx_done and o_rx_valid may pulse in the same cycle; they are independent.
- rst has priority over every other input.

Test Plan:
- CLOCKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, i_loopback=1, send 0xA5 -> o_tx_done exactly 40 cycles after the accept; o_rx_valid once with o_rx_data=0xA5; both error flags 0; o_tx_serial stays 1 throughout.
- Same configuration, i_loopback=0, 8-bit TX monitor on o_tx_serial -> line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Back-to-back 0x00 then 0xFF with i_tx_valid held high -> second start bit begins the cycle after the first o_tx_done, with no gap.
- PARITY=2 (even), DATA_BITS=7: drive i_rx_serial with frame 0x41 and parity bit 1 (wrong) -> o_rx_valid, o_rx_data=0x41, o_parity_err=1. Repeat with parity bit 0 -> o_parity_err=0.
- Drive a frame with 0x3C and the stop bit 0 -> o_rx_valid, o_rx_data=0x3C, o_frame_err=1. A following good frame 0x55 -> o_frame_err=0.
- Drive a 1-cycle low glitch on an idle i_rx_serial (CLOCKS_PER_BIT=8) -> no o_rx_valid and the RX FSM returns to IDLE.
- Assert rst for 1 cycle mid-DATA on both TX and RX -> next cycle o_tx_serial=1, o_tx_ready=1, no done or valid pulse. A fresh send of 0x5A after reset is received correctly in loopback.

Source files
------------

// File: rtl/uart_txrx_param.sv
// Parametrised UART transceiver: configurable width, parity and stop bits, line-error
// flags, TX ready handshake and internal loopback.
module uart_txrx_param #(
  parameter int unsigned CLOCKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_tx_done,
  output logic                 o_tx_serial,
  input  logic                 i_rx_serial,
  input  logic                 i_loopback,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic ODD        = (PARITY == 1);
  localparam logic HAS_PARITY = (PARITY != 0);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_line;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_done_d  = 1'b0;
    tx_line    = 1'b1;
    if (tx_state_q != TxIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TxIdle: begin
        if (i_tx_valid) begin
          tx_shift_d = i_tx_data;
          tx_par_d   = (^i_tx_data) ^ ODD;
          tx_idx_d   = '0;
          tx_cnt_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_d = TxData;
      end
      TxData: begin
        tx_line = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_d   = '0;
            tx_state_d = HAS_PARITY ? TxParity : TxStop;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      TxParity: begin
        tx_line = tx_par_q;
        if (tx_bit_end) tx_state_d = TxStop;
      end
      TxStop: begin
        // tx_idx_q is reused to count stop bits
        if (tx_bit_end) begin
          if (tx_idx_q == STOP_LAST) begin
            tx_idx_d   = '0;
            tx_done_d  = 1'b1;
            tx_state_d = TxIdle;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign o_tx_ready  = (tx_state_q == TxIdle);
  assign o_tx_done   = tx_done_q;
  assign o_tx_serial = i_loopback ? 1'b1 : tx_line;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RxIdle, RxStartChk, RxData, RxParity, RxStop} rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 rx_src, rx_bit_end;

  assign rx_src     = i_loopback ? tx_line : i_rx_serial;
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rx_src;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    if (rx_state_q != RxIdle) rx_cnt_d = rx_cnt_q + 1'b1;
    case (rx_state_q)
      RxIdle: begin
        // Edge, not level: a line stuck low after a frame error never restarts
        if (prev_q && !sync2_q) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = RxStartChk;
        end
      end
      RxStartChk: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = sync2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) begin
            rx_idx_d   = '0;
            rx_state_d = HAS_PARITY ? RxParity : RxStop;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RxParity: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_par_d   = sync2_q;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          ferr_d     = ~sync2_q;
          perr_d     = HAS_PARITY && (((^rx_shift_q) ^ ODD) != rx_par_q);
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;

endmodule
